// File: rtl/xm_stage_latch.sv
// Execute->memory pipeline latch sitting directly after the ALU.
// Captures the ALU result with its instruction context, resolves bne/blt and
// rewrites overflowing add/addi/sub into a write of an exception code to the
// status register. Single entry with valid/ready handshakes on both sides.
// Optional feature: define XM_PERF_CNT_EN to add retired/exception counters.
module xm_stage_latch #(
   parameter int unsigned W        = 32,
   parameter int unsigned RSTATUS  = 30,
   parameter int unsigned EXC_ADD  = 1,
   parameter int unsigned EXC_ADDI = 2,
   parameter int unsigned EXC_SUB  = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         x_valid,
   output logic         x_ready,
   input  logic [2:0]   x_cls,
   input  logic [W-1:0] x_pc,
   input  logic [W-1:0] x_imm,
   input  logic [4:0]   x_rd,
   input  logic [W-1:0] alu_result,
   input  logic         alu_ovf,
   input  logic         alu_ne,
   input  logic         alu_lt,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_result,
   output logic [4:0]   m_rd,
   output logic         m_we,
   output logic         m_exc,
   output logic         br_taken,
   output logic [W-1:0] br_target
`ifdef XM_PERF_CNT_EN
   ,
   output logic [31:0]  perf_retired,
   output logic [31:0]  perf_exc
`endif
);

   // Instruction classes presented by the execute stage.
   localparam logic [2:0] ClsAdd  = 3'd0;
   localparam logic [2:0] ClsAddi = 3'd1;
   localparam logic [2:0] ClsSub  = 3'd2;
   localparam logic [2:0] ClsAlu  = 3'd3;
   localparam logic [2:0] ClsBne  = 3'd4;
   localparam logic [2:0] ClsBlt  = 3'd5;

   localparam logic [W-1:0] ExcAddCode  = W'(EXC_ADD);
   localparam logic [W-1:0] ExcAddiCode = W'(EXC_ADDI);
   localparam logic [W-1:0] ExcSubCode  = W'(EXC_SUB);
   localparam logic [4:0]   RstatusReg  = 5'(RSTATUS);

   logic         valid_q;
   logic [W-1:0] result_q;
   logic [4:0]   rd_q;
   logic         we_q;
   logic         exc_q;
   logic         taken_q;
   logic [W-1:0] target_q;

   logic         accept;
   logic         pop;
   logic [W-1:0] result_d;
   logic [4:0]   rd_d;
   logic         we_d;
   logic         exc_d;
   logic         taken_d;
   logic [W-1:0] target_d;

   // Handshake: ready whenever the slot is empty or being drained this cycle.
   always_comb begin
      x_ready = !valid_q || m_ready;
      accept  = x_valid && x_ready;
      pop     = valid_q && m_ready;
   end

   // Decode the incoming instruction into the values it will present downstream.
   always_comb begin
      result_d = alu_result;
      rd_d     = x_rd;
      we_d     = 1'b0;
      exc_d    = 1'b0;
      taken_d  = 1'b0;
      target_d = x_pc + W'(1) + x_imm;
      unique case (x_cls)
         ClsAdd, ClsAddi, ClsSub, ClsAlu: we_d = (x_rd != 5'd0);
         ClsBne:                          taken_d = alu_ne;
         ClsBlt:                          taken_d = alu_lt && alu_ne;
         default:                         we_d = 1'b0;
      endcase
      // Only the arithmetic classes trap on overflow; others ignore alu_ovf.
      if (alu_ovf && (x_cls == ClsAdd || x_cls == ClsAddi || x_cls == ClsSub)) begin
         exc_d = 1'b1;
         we_d  = 1'b1;
         rd_d  = RstatusReg;
         unique case (x_cls)
            ClsAdd:  result_d = ExcAddCode;
            ClsAddi: result_d = ExcAddiCode;
            default: result_d = ExcSubCode;
         endcase
      end
   end

   // Pipeline register: reset > flush > accept > pop/hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
         we_q     <= 1'b0;
         exc_q    <= 1'b0;
         taken_q  <= 1'b0;
         target_q <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         taken_q <= 1'b0;
      end else if (accept) begin
         valid_q  <= 1'b1;
         result_q <= result_d;
         rd_q     <= rd_d;
         we_q     <= we_d;
         exc_q    <= exc_d;
         taken_q  <= taken_d;
         target_q <= target_d;
      end else begin
         // Payload fields keep their last values after a pop.
         valid_q <= valid_q && !m_ready;
         taken_q <= 1'b0;
      end
   end

   // Drive the memory-side outputs straight from the register.
   always_comb begin
      m_valid   = valid_q;
      m_result  = result_q;
      m_rd      = rd_q;
      m_we      = we_q;
      m_exc     = exc_q;
      br_taken  = taken_q;
      br_target = target_q;
   end

`ifdef XM_PERF_CNT_EN
   logic [31:0] retired_q;
   logic [31:0] exc_cnt_q;

   // Count every instruction leaving the latch and those that carried an exception.
   always_ff @(posedge clock) begin
      if (reset) begin
         retired_q <= '0;
         exc_cnt_q <= '0;
      end else if (pop) begin
         retired_q <= retired_q + 32'd1;
         if (exc_q) begin
            exc_cnt_q <= exc_cnt_q + 32'd1;
         end
      end
   end

   // Counter outputs.
   always_comb begin
      perf_retired = retired_q;
      perf_exc     = exc_cnt_q;
   end
`else
   logic unused_pop;

   // Pop only feeds the optional counters.
   always_comb begin
      unused_pop = pop;
   end
`endif

endmodule

// File: tb/tb_xm_stage_latch.sv
// Bench for xm_stage_latch: directed scenarios followed by random traffic,
// all checked against a rule-level reference model of the latch.
module tb_xm_stage_latch;

   logic        clock = 1'b0;
   logic        reset, flush, x_valid, x_ready;
   logic [2:0]  x_cls;
   logic [31:0] x_pc, x_imm, alu_result;
   logic [4:0]  x_rd;
   logic        alu_ovf, alu_ne, alu_lt;
   logic        m_valid, m_ready, m_we, m_exc, br_taken;
   logic [31:0] m_result, br_target;
   logic [4:0]  m_rd;
`ifdef XM_PERF_CNT_EN
   logic [31:0] perf_retired, perf_exc;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic        e_v, e_we, e_exc, e_tk;
   logic [31:0] e_res, e_tg, e_ret, e_excn;
   logic [4:0]  e_rd;

   always #5 clock = ~clock;

   xm_stage_latch dut (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .x_valid    (x_valid),
      .x_ready    (x_ready),
      .x_cls      (x_cls),
      .x_pc       (x_pc),
      .x_imm      (x_imm),
      .x_rd       (x_rd),
      .alu_result (alu_result),
      .alu_ovf    (alu_ovf),
      .alu_ne     (alu_ne),
      .alu_lt     (alu_lt),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_result   (m_result),
      .m_rd       (m_rd),
      .m_we       (m_we),
      .m_exc      (m_exc),
      .br_taken   (br_taken),
      .br_target  (br_target)
`ifdef XM_PERF_CNT_EN
      ,
      .perf_retired (perf_retired),
      .perf_exc     (perf_exc)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check x_ready, advance model, check outputs.
   task automatic step(input logic rst, input logic fl, input logic xv, input logic [2:0] cls,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                       input logic [31:0] res, input logic ovf, input logic ne,
                       input logic lt, input logic mr);
      logic acc, pop;
      @(negedge clock);
      reset = rst; flush = fl; x_valid = xv; x_cls = cls; x_pc = pc; x_imm = imm;
      x_rd = rd; alu_result = res; alu_ovf = ovf; alu_ne = ne; alu_lt = lt; m_ready = mr;
      #1;
      if (!rst) check("x_ready", {31'd0, x_ready}, {31'd0, (!e_v || mr)});
      acc = xv && (!e_v || mr);
      pop = e_v && mr;
      if (rst) begin
         e_v = 0; e_res = 0; e_rd = 0; e_we = 0; e_exc = 0; e_tk = 0; e_tg = 0;
         e_ret = 0; e_excn = 0;
      end else begin
         if (pop) begin
            e_ret = e_ret + 1;
            if (e_exc) e_excn = e_excn + 1;
         end
         if (fl) begin
            e_v = 0; e_tk = 0;
         end else if (acc) begin
            e_v = 1;
            if (cls <= 3'd2 && ovf) begin
               e_res = (cls == 3'd0) ? 32'd1 : (cls == 3'd1) ? 32'd2 : 32'd3;
               e_rd = 5'd30; e_we = 1; e_exc = 1;
            end else begin
               e_res = res; e_rd = rd; e_we = (cls <= 3'd3) && (rd != 5'd0); e_exc = 0;
            end
            e_tk = (cls == 3'd4 && ne) || (cls == 3'd5 && lt && ne);
            e_tg = pc + 32'd1 + imm;
         end else begin
            if (pop) e_v = 0;
            e_tk = 0;
         end
      end
      @(posedge clock);
      #1;
      check("m_valid", {31'd0, m_valid}, {31'd0, e_v});
      check("m_result", m_result, e_res);
      check("m_rd", {27'd0, m_rd}, {27'd0, e_rd});
      check("m_we", {31'd0, m_we}, {31'd0, e_we});
      check("m_exc", {31'd0, m_exc}, {31'd0, e_exc});
      check("br_taken", {31'd0, br_taken}, {31'd0, e_tk});
      if (e_tk || rst) check("br_target", br_target, e_tg);
`ifdef XM_PERF_CNT_EN
      check("perf_retired", perf_retired, e_ret);
      check("perf_exc", perf_exc, e_excn);
`endif
   endtask

   initial begin
      e_v = 0; e_res = 0; e_rd = 0; e_we = 0; e_exc = 0; e_tk = 0; e_tg = 0;
      e_ret = 0; e_excn = 0;
      reset = 1; flush = 0; x_valid = 0; x_cls = 0; x_pc = 0; x_imm = 0; x_rd = 0;
      alu_result = 0; alu_ovf = 0; alu_ne = 0; alu_lt = 0; m_ready = 0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("reset_result", m_result, 32'd0);

      // Plain add
      step(0, 0, 1, 0, 32'h4, 0, 5'd7, 32'd5, 0, 0, 0, 1);
      check("add_result", m_result, 32'd5);
      check("add_rd", {27'd0, m_rd}, 32'd7);

      // Sub overflow rewrite
      step(0, 0, 1, 2, 32'h5, 0, 5'd9, 32'h8000_0000, 1, 0, 0, 1);
      check("sub_exc_code", m_result, 32'd3);
      check("sub_exc_rd", {27'd0, m_rd}, 32'd30);

      // Taken bne with negative offset, then the pulse must drop
      step(0, 0, 1, 4, 32'h10, 32'hFFFF_FFFE, 5'd3, 32'd1, 0, 1, 0, 1);
      check("bne_target", br_target, 32'h0000_000F);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      // Stall with a held instruction; offered instruction waits
      step(0, 0, 1, 3, 32'h20, 0, 5'd4, 32'hAAAA_5555, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'h21, 0, 5'd6, 32'h1234, 0, 0, 0, 0);
      check("stall_hold", m_result, 32'hAAAA_5555);
      step(0, 0, 1, 1, 32'h21, 0, 5'd6, 32'h1234, 0, 0, 0, 1);
      check("pop_accept", m_result, 32'h1234);

      // Flush kills an incoming taken blt
      step(0, 1, 1, 5, 32'h30, 32'd8, 5'd2, 32'd0, 0, 1, 1, 1);
      // blt with lt but equal is not taken; taken blt wraps target
      step(0, 0, 1, 5, 32'h30, 32'd8, 5'd2, 32'd0, 0, 0, 1, 1);
      step(0, 0, 1, 5, 32'hFFFF_FFFF, 32'd0, 5'd2, 32'd0, 0, 1, 1, 1);
      check("blt_wrap", br_target, 32'd0);
      // Overflow ignored for other ALU classes; rd 0 suppresses write
      step(0, 0, 1, 3, 32'h40, 0, 5'd0, 32'd77, 1, 0, 0, 1);
      step(0, 0, 1, 0, 32'h41, 0, 5'd0, 32'd1, 1, 0, 0, 0);
      step(0, 0, 1, 1, 32'h42, 0, 5'd5, 32'd1, 1, 0, 0, 0);
      // Reset while stalled
      step(1, 0, 1, 0, 0, 0, 5'd1, 32'd9, 0, 0, 0, 0);
      check("reset_stall_valid", {31'd0, m_valid}, 32'd0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 6)), $urandom, $urandom,
              5'($urandom_range(0, 31) & (($urandom_range(0, 3) == 0) ? 0 : 31)), $urandom,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, ($urandom_range(0, 9) < 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
